// File: rtl/mem_ctrl_defs_pkg.sv
// Shared memory-control encodings: load/store funct3 values and the MEM-stage FSM states.
// The EX-stage decoder imports this same package so both stages agree on widths.
package mem_ctrl_defs;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mem_state_t;

   // Halfwords need an even address and words need a 4-byte-aligned address.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic r_mis;
      r_mis = 1'b0;
      case (funct3)
         MEM_H, MEM_HU: r_mis = off[0];
         MEM_W:         r_mis = (off != 2'b00);
         default:       r_mis = 1'b0;
      endcase
      return r_mis;
   endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Data-path alignment: store lane replication and byte enables, plus load
// byte/halfword extraction with sign or zero extension.
module mem_align
   import mem_ctrl_defs::*;
(
   input  logic        st_we_i,
   input  logic [2:0]  st_funct3_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_be_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
   assign w_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      st_wdata_o = st_data_i;
      st_be_o    = 4'b1111;
      if (st_we_i) begin
         case (st_funct3_i[1:0])
            2'b00: begin
               st_wdata_o = {4{st_data_i[7:0]}};
               st_be_o    = 4'b0001 << st_off_i;
            end
            2'b01: begin
               st_wdata_o = {2{st_data_i[15:0]}};
               st_be_o    = 4'b0011 << st_off_i;
            end
            default: begin
               st_wdata_o = st_data_i;
               st_be_o    = 4'b1111;
            end
         endcase
      end
   end

   always_comb begin
      ld_data_o = ld_rdata_i;
      case (ld_funct3_i)
         MEM_B:   ld_data_o = {{24{w_byte[7]}}, w_byte};
         MEM_BU:  ld_data_o = {24'h0, w_byte};
         MEM_H:   ld_data_o = {{16{w_half[15]}}, w_half};
         MEM_HU:  ld_data_o = {16'h0, w_half};
         default: ld_data_o = ld_rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data bus, stalls the pipeline
// while an access is outstanding and reports misaligned accesses and bus timeouts.
module mem_access_unit
   import mem_ctrl_defs::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_valid_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              mem_wr_en_i,
   input  logic              mem_rd_en_i,
   input  logic [3:0]        mem_ctrl_i,
   input  logic              advance_i,
   input  logic              flush_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [3:0]        dmem_be_o,
   output logic [31:0]       dmem_wdata_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [31:0]       dmem_rdata_i,
   output logic [31:0]       load_data_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic [31:0]       misalign_addr_o,
   output logic              bus_err_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   mem_state_t        r_state, w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_wdata;
   logic [31:0]       r_load_data;
   logic              r_misalign;
   logic [31:0]       r_misalign_addr;
   logic              r_bus_err;

   logic        w_access, w_misaligned, w_start, w_busy;
   logic        w_resp, w_drop, w_timeout, w_tmo_fire;
   logic [31:0] w_st_wdata, w_ld_data;
   logic [3:0]  w_st_be;

   assign w_access     = pc_valid_i & (mem_rd_en_i | mem_wr_en_i) & ~flush_i;
   assign w_misaligned = is_misaligned(mem_ctrl_i[2:0], addr_i[1:0]);
   assign w_start      = w_access & ~w_misaligned;
   assign w_busy       = (r_state == ST_REQ) || (r_state == ST_WAIT);
   assign w_resp       = ((r_state == ST_REQ) & dmem_gnt_i & dmem_rvalid_i) |
                         ((r_state == ST_WAIT) & dmem_rvalid_i);
   assign w_drop       = (r_state == ST_REQ) & flush_i & ~dmem_gnt_i;
   assign w_timeout    = (TIMEOUT_CYCLES != 0) && w_busy && (r_cnt == CNT_LAST);
   assign w_tmo_fire   = w_timeout & ~w_resp & ~w_drop;

   mem_align u_align (
      .st_we_i     (mem_wr_en_i),
      .st_funct3_i (mem_ctrl_i[2:0]),
      .st_off_i    (addr_i[1:0]),
      .st_data_i   (wdata_i),
      .st_wdata_o  (w_st_wdata),
      .st_be_o     (w_st_be),
      .ld_funct3_i (r_funct3),
      .ld_off_i    (r_off),
      .ld_rdata_i  (dmem_rdata_i),
      .ld_data_o   (w_ld_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_next_state = ST_REQ;
         ST_REQ: begin
            if (w_drop)                              w_next_state = ST_IDLE;
            else if (dmem_gnt_i && dmem_rvalid_i)    w_next_state = ST_DONE;
            else if (w_timeout)                      w_next_state = ST_DONE;
            else if (dmem_gnt_i)                     w_next_state = ST_WAIT;
         end
         ST_WAIT: if (dmem_rvalid_i || w_timeout) w_next_state = ST_DONE;
         ST_DONE: if (advance_i) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      dmem_req_o = (r_state == ST_REQ);
      dmem_we_o  = r_we & (r_state == ST_REQ);
      case (r_state)
         ST_IDLE:         stall_o = w_start;
         ST_REQ, ST_WAIT: stall_o = 1'b1;
         default:         stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt           <= '0;
         r_we            <= 1'b0;
         r_funct3        <= 3'b000;
         r_off           <= 2'b00;
         r_addr          <= '0;
         r_be            <= 4'b0000;
         r_wdata         <= 32'h0;
         r_load_data     <= 32'h0;
         r_misalign      <= 1'b0;
         r_misalign_addr <= 32'h0;
         r_bus_err       <= 1'b0;
      end else begin
         r_cnt      <= w_busy ? r_cnt + 1'b1 : '0;
         r_misalign <= (r_state == ST_IDLE) & w_access & w_misaligned;
         r_bus_err  <= w_tmo_fire;
         if ((r_state == ST_IDLE) && w_access && w_misaligned)
            r_misalign_addr <= addr_i;
         // Request fields are frozen at issue so they stay stable until granted.
         if ((r_state == ST_IDLE) && w_start) begin
            r_we     <= mem_wr_en_i;
            r_funct3 <= mem_ctrl_i[2:0];
            r_off    <= addr_i[1:0];
            r_addr   <= {addr_i[ADDR_W-1:2], 2'b00};
            r_be     <= w_st_be;
            r_wdata  <= w_st_wdata;
         end
         if (w_resp && !r_we)
            r_load_data <= w_ld_data;
         else if (w_tmo_fire)
            r_load_data <= 32'h0;
      end
   end

   assign dmem_addr_o     = r_addr;
   assign dmem_be_o       = r_be;
   assign dmem_wdata_o    = r_wdata;
   assign load_data_o     = r_load_data;
   assign misalign_o      = r_misalign;
   assign misalign_addr_o = r_misalign_addr;
   assign bus_err_o       = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short bus timeout.
module tb_mem_access_unit;
   import mem_ctrl_defs::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_valid_i, mem_wr_en_i, mem_rd_en_i, advance_i, flush_i;
   logic [31:0] addr_i, wdata_i;
   logic [3:0]  mem_ctrl_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] load_data_o;
   logic        stall_o, misalign_o, bus_err_o;
   logic [31:0] misalign_addr_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_valid_i      (pc_valid_i),
      .addr_i          (addr_i),
      .wdata_i         (wdata_i),
      .mem_wr_en_i     (mem_wr_en_i),
      .mem_rd_en_i     (mem_rd_en_i),
      .mem_ctrl_i      (mem_ctrl_i),
      .advance_i       (advance_i),
      .flush_i         (flush_i),
      .dmem_req_o      (dmem_req_o),
      .dmem_we_o       (dmem_we_o),
      .dmem_addr_o     (dmem_addr_o),
      .dmem_be_o       (dmem_be_o),
      .dmem_wdata_o    (dmem_wdata_o),
      .dmem_gnt_i      (dmem_gnt_i),
      .dmem_rvalid_i   (dmem_rvalid_i),
      .dmem_rdata_i    (dmem_rdata_i),
      .load_data_o     (load_data_o),
      .stall_o         (stall_o),
      .misalign_o      (misalign_o),
      .misalign_addr_o (misalign_addr_o),
      .bus_err_o       (bus_err_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      pc_valid_i    = 1'b0;
      mem_wr_en_i   = 1'b0;
      mem_rd_en_i   = 1'b0;
      mem_ctrl_i    = 4'h0;
      addr_i        = 32'h0;
      wdata_i       = 32'h0;
      advance_i     = 1'b0;
      flush_i       = 1'b0;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h0;
   endtask

   task automatic issue(input logic wr, input logic rd, input logic [3:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] data);
      pc_valid_i  = 1'b1;
      mem_wr_en_i = wr;
      mem_rd_en_i = rd;
      mem_ctrl_i  = ctrl;
      addr_i      = addr;
      wdata_i     = data;
   endtask

   task automatic drop_instr();
      pc_valid_i  = 1'b0;
      mem_wr_en_i = 1'b0;
      mem_rd_en_i = 1'b0;
   endtask

   // Single-cycle bus load: issue in IDLE, gnt+rvalid in REQ, check in DONE, then advance.
   task automatic do_load(input string tag, input logic [3:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
      issue(1'b0, 1'b1, ctrl, addr, 32'h0);
      tick();
      drop_instr();
      dmem_gnt_i    = 1'b1;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      tick();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      check(tag, load_data_o, exp);
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #1;
      check("rst_req", {31'h0, dmem_req_o}, 32'h0);
      check("rst_stall", {31'h0, stall_o}, 32'h0);
      check("rst_load_data", load_data_o, 32'h0);
      check("rst_be", {28'h0, dmem_be_o}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // LW 0x100, grant and response on the first REQ cycle
      issue(1'b0, 1'b1, {1'b0, MEM_W}, 32'h0000_0100, 32'h0);
      #1;
      check("lw_stall_idle", {31'h0, stall_o}, 32'h1);
      check("lw_req_idle", {31'h0, dmem_req_o}, 32'h0);
      tick();
      drop_instr();
      dmem_gnt_i    = 1'b1;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hDEAD_BEEF;
      #1;
      check("lw_req", {31'h0, dmem_req_o}, 32'h1);
      check("lw_stall_req", {31'h0, stall_o}, 32'h1);
      check("lw_addr", dmem_addr_o, 32'h0000_0100);
      check("lw_be", {28'h0, dmem_be_o}, 32'hF);
      check("lw_we", {31'h0, dmem_we_o}, 32'h0);
      tick();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      check("lw_stall_done", {31'h0, stall_o}, 32'h0);
      check("lw_req_done", {31'h0, dmem_req_o}, 32'h0);
      check("lw_data", load_data_o, 32'hDEAD_BEEF);
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;

      // Grant withheld: timeout after 8 cycles in REQ
      issue(1'b0, 1'b1, {1'b0, MEM_W}, 32'h0000_0300, 32'h0);
      tick();
      drop_instr();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tmo_req_%0d", i), {31'h0, dmem_req_o}, 32'h1);
         check($sformatf("tmo_noerr_%0d", i), {31'h0, bus_err_o}, 32'h0);
         tick();
      end
      check("tmo_bus_err", {31'h0, bus_err_o}, 32'h1);
      check("tmo_req_drop", {31'h0, dmem_req_o}, 32'h0);
      check("tmo_load_zero", load_data_o, 32'h0);
      check("tmo_stall", {31'h0, stall_o}, 32'h0);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hFFFF_FFFF;
      tick();
      dmem_rvalid_i = 1'b0;
      check("tmo_err_pulse", {31'h0, bus_err_o}, 32'h0);
      check("tmo_late_rvalid", load_data_o, 32'h0);
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;

      // Back in IDLE (stall follows a new access), then flush while in REQ
      issue(1'b0, 1'b1, {1'b0, MEM_W}, 32'h0000_0500, 32'h0);
      #1;
      check("tmo_idle_again", {31'h0, stall_o}, 32'h1);
      tick();
      drop_instr();
      flush_i = 1'b1;
      #1;
      check("flush_req_before", {31'h0, dmem_req_o}, 32'h1);
      tick();
      flush_i = 1'b0;
      check("flush_req_dropped", {31'h0, dmem_req_o}, 32'h0);
      check("flush_stall", {31'h0, stall_o}, 32'h0);

      // Byte/halfword loads at offsets 3 and 2 (ctrl[3] set on LBU must be ignored)
      do_load("lb_0x103", {1'b0, MEM_B}, 32'h0000_0103, 32'h8011_2233, 32'hFFFF_FF80);
      do_load("lbu_0x103", {1'b1, MEM_BU}, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080);
      do_load("lb_0x100", {1'b0, MEM_B}, 32'h0000_0100, 32'h8011_2233, 32'h0000_0033);
      do_load("lh_0x102", {1'b0, MEM_H}, 32'h0000_0102, 32'h8011_2233, 32'hFFFF_8011);
      do_load("lhu_0x102", {1'b0, MEM_HU}, 32'h0000_0102, 32'h8011_2233, 32'h0000_8011);

      // SH 0x206: grant after one cycle, ack two cycles later
      issue(1'b1, 1'b0, {1'b0, MEM_H}, 32'h0000_0206, 32'h1234_ABCD);
      #1;
      check("sh_stall_idle", {31'h0, stall_o}, 32'h1);
      tick();
      drop_instr();
      check("sh_addr", dmem_addr_o, 32'h0000_0204);
      check("sh_be", {28'h0, dmem_be_o}, 32'hC);
      check("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
      check("sh_we", {31'h0, dmem_we_o}, 32'h1);
      tick();
      check("sh_req_held", {31'h0, dmem_req_o}, 32'h1);
      check("sh_addr_held", dmem_addr_o, 32'h0000_0204);
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      check("sh_wait_req", {31'h0, dmem_req_o}, 32'h0);
      check("sh_wait_stall0", {31'h0, stall_o}, 32'h1);
      tick();
      check("sh_wait_stall1", {31'h0, stall_o}, 32'h1);
      dmem_rvalid_i = 1'b1;
      tick();
      dmem_rvalid_i = 1'b0;
      check("sh_done_stall", {31'h0, stall_o}, 32'h0);
      check("sh_load_kept", load_data_o, 32'h0000_8011);
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;

      // SB with both enables set behaves as a store
      issue(1'b1, 1'b1, {1'b0, MEM_B}, 32'h0000_0101, 32'h5555_55EF);
      tick();
      drop_instr();
      check("sb_we", {31'h0, dmem_we_o}, 32'h1);
      check("sb_be", {28'h0, dmem_be_o}, 32'h2);
      check("sb_wdata", dmem_wdata_o, 32'hEFEF_EFEF);
      check("sb_addr", dmem_addr_o, 32'h0000_0100);
      dmem_gnt_i    = 1'b1;
      dmem_rvalid_i = 1'b1;
      tick();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      check("sb_load_kept", load_data_o, 32'h0000_8011);
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;

      // LW at 0x102 is misaligned: no request, no stall, one-cycle flag
      issue(1'b0, 1'b1, {1'b0, MEM_W}, 32'h0000_0102, 32'h0);
      #1;
      check("mis_stall", {31'h0, stall_o}, 32'h0);
      tick();
      drop_instr();
      check("mis_flag", {31'h0, misalign_o}, 32'h1);
      check("mis_addr", misalign_addr_o, 32'h0000_0102);
      check("mis_no_req", {31'h0, dmem_req_o}, 32'h0);
      tick();
      check("mis_pulse_end", {31'h0, misalign_o}, 32'h0);
      check("mis_still_no_req", {31'h0, dmem_req_o}, 32'h0);

      // Reset asserted while in WAIT (flush there is ignored)
      issue(1'b0, 1'b1, {1'b0, MEM_W}, 32'h0000_0404, 32'h0);
      tick();
      drop_instr();
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      flush_i    = 1'b1;
      tick();
      flush_i = 1'b0;
      check("wait_flush_stall", {31'h0, stall_o}, 32'h1);
      check("wait_flush_req", {31'h0, dmem_req_o}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("rstw_stall", {31'h0, stall_o}, 32'h0);
      check("rstw_load_data", load_data_o, 32'h0);
      check("rstw_addr", dmem_addr_o, 32'h0);
      check("rstw_be", {28'h0, dmem_be_o}, 32'h0);
      check("rstw_mis_addr", misalign_addr_o, 32'h0);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hDEAD_BEEF;
      tick();
      rst_n = 1'b1;
      tick();
      dmem_rvalid_i = 1'b0;
      check("rstw_late_rvalid", load_data_o, 32'h0);
      check("rstw_idle_stall", {31'h0, stall_o}, 32'h0);
      issue(1'b0, 1'b1, {1'b0, MEM_W}, 32'h0000_0408, 32'h0);
      #1;
      check("rstw_idle_access", {31'h0, stall_o}, 32'h1);
      drop_instr();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
